// File: rtl/pkt_tx_builder.sv
// Transmit framer: header, node fields, packed payload and XOR checksum, one word per handshake.
// Latency: first word valid the cycle after an accepted start; each payload word adds a 2-3 cycle fetch gap.
// Backpressure: txData/txLast hold while txValid && !txReady; start is ignored while a frame is in flight.
//
// Ports:
//   clk, nrst                    clock (rising edge), asynchronous active-low reset
//   start, pktType               build request (one cycle) and frame type 0..3
//   myNodeID..chosenCH, nextHop  node fields and destination, captured on accepted start
//   payloadBase, payloadLen      payload source address and byte count (DP only)
//   memRdEn, memAddr, memData    byte-wide packet memory read port, data one cycle after strobe
//   txData, txValid, txReady     frame word stream
//   txLast, busy, txDone         checksum marker, frame in progress, completion pulse
module pkt_tx_builder #(
   parameter int WORD_WIDTH  = 16,
   parameter int MEM_DEPTH   = 2048,
   parameter int MEM_WIDTH   = 8,
   parameter int ADDR_WIDTH  = 11,
   parameter int MAX_PAYLOAD = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [2:0]            pktType,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] myHops,
   input  logic [WORD_WIDTH-1:0] myQValue,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] hopsFromCH,
   input  logic [WORD_WIDTH-1:0] chosenCH,
   input  logic [WORD_WIDTH-1:0] nextHop,
   input  logic [ADDR_WIDTH-1:0] payloadBase,
   input  logic [4:0]            payloadLen,
   output logic                  memRdEn,
   output logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [MEM_WIDTH-1:0]  memData,
   output logic [WORD_WIDTH-1:0] txData,
   output logic                  txValid,
   input  logic                  txReady,
   output logic                  txLast,
   output logic                  busy,
   output logic                  txDone
);

   typedef enum logic [2:0] {S_IDLE, S_FIELDS, S_FETCH, S_PAY, S_CSUM} state_t;

   localparam logic [4:0]            LP_MAX_LEN   = 5'(MAX_PAYLOAD);
   localparam logic [ADDR_WIDTH-1:0] LP_ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_t                r_state, w_state_nxt;
   logic [2:0]            r_type;
   logic [WORD_WIDTH-1:0] r_next_hop, r_node_id, r_hops, r_qval, r_energy, r_hops_ch, r_chosen_ch;
   logic [4:0]            r_len, r_k;
   logic [2:0]            r_idx;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_fph;       // fetch phase: 0 read k, 1 capture k / read k+1, 2 capture k+1
   logic [MEM_WIDTH-1:0]  r_hi, r_lo;
   logic [WORD_WIDTH-1:0] r_csum;
   logic                  r_done;

   logic                  w_accept, w_fire, w_second;
   logic [4:0]            w_len_in, w_k_next;
   logic [5:0]            w_len_p1;
   logic [7:0]            w_total;
   logic [ADDR_WIDTH-1:0] w_addr_inc;
   logic [WORD_WIDTH-1:0] w_field;

   // r_done blocks the cycle of the txDone pulse, so back-to-back starts land one cycle later.
   assign w_accept   = start && (r_state == S_IDLE) && !pktType[2] && !r_done;
   assign w_fire     = txValid && txReady;
   assign w_len_p1   = {1'b0, r_len} + 6'd1;
   assign w_total    = 8'd9 + 8'(w_len_p1 >> 1);
   assign w_second   = ({1'b0, r_k} + 6'd1) < {1'b0, r_len};
   assign w_k_next   = r_k + 5'd2;
   assign w_addr_inc = (r_addr == LP_ADDR_LAST) ? '0
                     : r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   assign busy   = (r_state != S_IDLE);
   assign txDone = r_done;

   always_comb begin
      w_len_in = '0;
      if (pktType == 3'd3)
         w_len_in = (payloadLen > LP_MAX_LEN) ? LP_MAX_LEN : payloadLen;
   end

   always_comb begin
      w_field = '0;
      case (r_idx)
         3'd0:    w_field = WORD_WIDTH'({r_type, 5'b0, w_total});
         3'd1:    w_field = r_next_hop;
         3'd2:    w_field = r_node_id;
         3'd3:    w_field = r_hops;
         3'd4:    w_field = r_qval;
         3'd5:    w_field = r_energy;
         3'd6:    w_field = r_hops_ch;
         default: w_field = r_chosen_ch;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      txValid     = 1'b0;
      txData      = '0;
      txLast      = 1'b0;
      memRdEn     = 1'b0;
      memAddr     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_FIELDS;
         end
         S_FIELDS: begin
            txValid = 1'b1;
            txData  = w_field;
            if (txReady && r_idx == 3'd7)
               w_state_nxt = (r_len != 5'd0) ? S_FETCH : S_CSUM;
         end
         S_FETCH: begin
            if (r_fph == 2'd0 || (r_fph == 2'd1 && w_second)) begin
               memRdEn = 1'b1;
               memAddr = r_addr;
            end
            if ((r_fph == 2'd1 && !w_second) || r_fph == 2'd2)
               w_state_nxt = S_PAY;
         end
         S_PAY: begin
            txValid = 1'b1;
            txData  = WORD_WIDTH'({r_hi, r_lo});
            if (txReady)
               w_state_nxt = (w_k_next < r_len) ? S_FETCH : S_CSUM;
         end
         S_CSUM: begin
            txValid = 1'b1;
            txData  = r_csum;
            txLast  = 1'b1;
            if (txReady) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_type      <= '0;
         r_next_hop  <= '0;
         r_node_id   <= '0;
         r_hops      <= '0;
         r_qval      <= '0;
         r_energy    <= '0;
         r_hops_ch   <= '0;
         r_chosen_ch <= '0;
         r_len       <= '0;
         r_k         <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_fph       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_csum      <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_type      <= pktType;
                  r_next_hop  <= nextHop;
                  r_node_id   <= myNodeID;
                  r_hops      <= myHops;
                  r_qval      <= myQValue;
                  r_energy    <= myEnergy;
                  r_hops_ch   <= hopsFromCH;
                  r_chosen_ch <= chosenCH;
                  r_len       <= w_len_in;
                  r_k         <= '0;
                  r_idx       <= '0;
                  r_addr      <= payloadBase;
                  r_fph       <= '0;
                  r_csum      <= '0;
               end
            end
            S_FIELDS: begin
               if (w_fire) begin
                  r_csum <= r_csum ^ txData;
                  r_idx  <= r_idx + 3'd1;
               end
            end
            S_FETCH: begin
               case (r_fph)
                  2'd0: begin
                     r_addr <= w_addr_inc;
                     r_fph  <= 2'd1;
                  end
                  2'd1: begin
                     r_hi <= memData;
                     if (w_second) begin
                        r_addr <= w_addr_inc;
                        r_fph  <= 2'd2;
                     end else begin
                        r_lo  <= '0;   // odd length: pad the final low byte
                        r_fph <= 2'd0;
                     end
                  end
                  default: begin
                     r_lo  <= memData;
                     r_fph <= 2'd0;
                  end
               endcase
            end
            S_PAY: begin
               if (w_fire) begin
                  r_csum <= r_csum ^ txData;
                  r_k    <= w_k_next;
               end
            end
            S_CSUM: begin
               if (w_fire) begin
                  r_csum <= '0;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pkt_tx_builder.md
Name: pkt_tx_builder

Overview:
- Transmit-side framer for the node's radio path; the counterpart of the receive-side Q-table update / best-hop logic, which parses the same word fields.
- On a start pulse it captures the node's own info (ID, hops, Q-value, energy, hopsFromCH, chosenCH) and the chosen next hop, then emits the frame one word per handshake.
- For data packets it appends a payload fetched byte-wise from packet memory, packed two bytes per word, and closes every frame with an XOR checksum word.

Parameters:
WORD_WIDTH, 16, width of every frame word and node-info field
MEM_DEPTH, 2048, packet memory depth in bytes
MEM_WIDTH, 8, packet memory data width (bytes)
ADDR_WIDTH, 11, memory address width (log2 MEM_DEPTH)
MAX_PAYLOAD, 16, maximum payload bytes per data packet

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to build a frame
pktType  in  3  0=HB, 1=CHE, 2=MR, 3=DP; 4..7 invalid
myNodeID, myHops, myQValue, myEnergy  in  WORD_WIDTH each  own node fields
hopsFromCH, chosenCH  in  WORD_WIDTH each  from known-CH logic
nextHop  in  WORD_WIDTH  destination ID; 16'hFFFF = broadcast
payloadBase  in  ADDR_WIDTH  first payload byte address
payloadLen  in  5  payload bytes (DP only)
memRdEn  out  1  memory read strobe
memAddr  out  ADDR_WIDTH  memory read address
memData  in  MEM_WIDTH  read data, valid the cycle after memRdEn
txData  out  WORD_WIDTH  frame word
txValid  out  1  txData valid
txReady  in  1  sink accepts the word
txLast  out  1  high with the checksum word
busy  out  1  frame in progress
txDone  out  1  one-cycle pulse after the checksum transfers

Behaviour:
- Reset: all outputs 0; state S_IDLE; checksum accumulator 0. Reset asserted mid-frame aborts the frame immediately. No partial frame resumes after reset.
- Start acceptance: start is accepted only in S_IDLE with pktType <= 3. All inputs are captured on that edge and busy goes high the next cycle.
  - Invalid type: start is ignored; busy stays 0.
  - Start while busy: ignored.
  - payloadLen > MAX_PAYLOAD: clamped to MAX_PAYLOAD.
  - Non-DP types: payload length forced to 0.
- Frame word order:
  - w0 header = {pktType, 5'b0, totalWords[7:0]}
  - w1 nextHop, w2 myNodeID, w3 myHops, w4 myQValue, w5 myEnergy, w6 hopsFromCH, w7 chosenCH
  - payload words: byte k in [15:8], byte k+1 in [7:0]; odd length pads the final low byte with 8'h00
  - checksum = XOR of w0 through the last payload word
  - totalWords = 9 + ceil(len/2)
- Handshake:
  - A word transfers on a cycle with txValid && txReady.
  - While txValid && !txReady, txData and txLast hold stable.
  - txValid never drops without a transfer.
  - The first txValid occurs the cycle after start is accepted.
- States:
  - S_IDLE: waits for an accepted start, then goes to S_FIELDS.
  - S_FIELDS: an index 0..7 sends w0..w7. After w7 transfers: len>0 goes to S_FETCH, else S_CSUM.
  - S_FETCH: issues memRdEn for byte k, then byte k+1 (if k+1 < len), on consecutive cycles with incrementing memAddr. It registers both bytes and goes to S_PAY. txValid is low during S_FETCH.
  - S_PAY: presents the packed word. On transfer, k += 2; if k < len go to S_FETCH, else S_CSUM.
  - S_CSUM: presents the checksum with txLast=1. On transfer: txDone=1 for one cycle, busy=0, accumulator cleared, next state S_IDLE.
- Memory rules:
  - memAddr wraps modulo MEM_DEPTH.
  - memRdEn is never asserted outside S_FETCH.
  - The accumulator XORs each word as it transfers.
- Timing: with txReady tied high, back-to-back starts are accepted no sooner than the cycle after txDone.

Test Plan:
- HB frame: pktType=0, nextHop=FFFF, myNodeID=0005, myHops=2, myQValue=0100, myEnergy=0F00, hopsFromCH=2, chosenCH=0003, txReady=1.
  - 9 words: 0009, FFFF, 0005, 0002, 0100, 0F00, 0002, 0003, then XOR of the above with txLast.
  - txDone one cycle later; no memRdEn.
- DP with odd payload: pktType=3, len=3, payloadBase=07FF, memory holds AA at 07FF, BB at 0000, CC at 0001.
  - Header 600B; payload words AABB, CC00; memAddr wraps 07FF→0000; 11 words total.
- Backpressure: txReady low for 5 cycles while w4 is presented.
  - txData holds myQValue and txValid stays 1; the frame completes intact with the correct checksum.
- Ignored starts: start pulses during busy, and start with pktType=5 while idle.
  - Neither starts a new frame; the current frame is unaltered.
  - DP with len=0 gives a 9-word frame with header 6009; len=20 is clamped to 16 bytes, header 6011.
- Reset mid-frame: nrst low during S_PAY.
  - All outputs 0 asynchronously. After release, MR start (pktType=2) gives a clean frame with header 4009 and a checksum over that frame only.
